// File: rtl/io_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_port_ctrl_pkg
// Brief    : Register map, segment constants and debounce state type for the
//            board I/O responder.
// Revision : 1.0 - initial release
// ============================================================================
package io_port_ctrl_pkg;

  localparam int NUM_KEYS   = 4;
  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] IO_SW      = 8'h00;
  localparam logic [7:0] IO_KEYLVL  = 8'h04;
  localparam logic [7:0] IO_KEYEVT  = 8'h08;
  localparam logic [7:0] IO_LEDREG  = 8'h0C;
  localparam logic [7:0] IO_HEX     = 8'h10;
  localparam logic [7:0] IO_BLANK   = 8'h14;
  localparam logic [7:0] IO_IRQMASK = 8'h18;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [0:0] {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_t;

endpackage
`default_nettype wire

// File: rtl/io_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : io_port_ctrl_if
// Brief    : CPU data-memory side bus into the board I/O register file.
// Revision : 1.0 - initial release
// ============================================================================
interface io_port_ctrl_if;

  logic [7:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output io_addr,
    output io_we,
    output io_re,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_addr,
    input  io_we,
    input  io_re,
    input  io_wdata,
    output io_rdata
  );

endinterface
`default_nettype wire

// File: rtl/io_port_ctrl_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Brief    : 4-bit value to active-low 7-segment pattern, bit order gfedcba.
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_port_ctrl
// Brief    : Memory-mapped KEY/SW/LED/7-segment responder with key debounce.
//            Optional macro IO_KEY_IRQ_EN adds IRQMASK and the key interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic          clock,
  input  logic          reset,
  io_port_ctrl_if.slave bus,
  input  logic [3:0]    KEY,
  input  logic [9:0]    SW,
  output logic [9:0]    LED,
  output logic [6:0]    SEG0,
  output logic [6:0]    SEG1,
  output logic [6:0]    SEG2,
  output logic [6:0]    SEG3,
  output logic [6:0]    SEG4,
  output logic [6:0]    SEG5,
  output logic          irq
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_key_meta, r_key_sync, r_key_stable;
  logic [NUM_KEYS-1:0] w_key_flip, w_key_rise;
  logic [9:0]          r_sw_meta, r_sw_sync;

  // KEY is inverted ahead of the chain so every key flop holds 1 = pressed
  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_meta <= '0;
      r_key_sync <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_key_meta <= ~KEY;
      r_key_sync <= r_key_meta;
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    db_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_differ, w_flip;

    assign w_differ      = r_key_sync[k] != r_key_stable[k];
    assign w_key_flip[k] = w_flip;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_state <= DB_STABLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_flip      = 1'b0;
      case (r_state)
        DB_STABLE: begin
          w_cnt_nxt = '0;
          if (w_differ) begin
            w_state_nxt = DB_COUNTING;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        DB_COUNTING: begin
          if (!w_differ) begin
            w_state_nxt = DB_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_CNT_LAST) begin
            w_flip      = 1'b1;
            w_state_nxt = DB_STABLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign w_key_rise = w_key_flip & ~r_key_stable;

  logic [7:0]            w_addr;
  logic                  w_wr_evt, w_wr_led, w_wr_hex, w_wr_blank;
  logic [NUM_KEYS-1:0]   r_evt, w_evt_nxt, w_evt_clr;
  logic [9:0]            r_led;
  logic [23:0]           r_hex, w_hex_nxt;
  logic [NUM_DIGITS-1:0] r_blank, w_blank_nxt;
  logic [9:0]            w_unused_bits;

  assign w_addr        = {bus.io_addr[7:2], 2'b00};
  assign w_unused_bits = {bus.io_addr[1:0], bus.io_wdata[31:24]};

  assign w_wr_evt   = bus.io_we && (w_addr == IO_KEYEVT);
  assign w_wr_led   = bus.io_we && (w_addr == IO_LEDREG);
  assign w_wr_hex   = bus.io_we && (w_addr == IO_HEX);
  assign w_wr_blank = bus.io_we && (w_addr == IO_BLANK);

  // A key rise in the same cycle as a W1C of that bit keeps the bit set
  assign w_evt_clr   = w_wr_evt ? bus.io_wdata[NUM_KEYS-1:0] : '0;
  assign w_evt_nxt   = (r_evt & ~w_evt_clr) | w_key_rise;
  assign w_hex_nxt   = w_wr_hex ? bus.io_wdata[23:0] : r_hex;
  assign w_blank_nxt = w_wr_blank ? bus.io_wdata[NUM_DIGITS-1:0] : r_blank;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_stable <= '0;
      r_evt        <= '0;
      r_led        <= '0;
      r_hex        <= '0;
      r_blank      <= '0;
    end else begin
      r_key_stable <= r_key_stable ^ w_key_flip;
      r_evt        <= w_evt_nxt;
      r_hex        <= w_hex_nxt;
      r_blank      <= w_blank_nxt;
      if (w_wr_led) r_led <= bus.io_wdata[9:0];
    end
  end

  assign LED = r_led;

  logic [NUM_DIGITS-1:0][6:0] w_seg_dec, r_seg;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    hex7seg u_hex7seg (
      .i_hex (w_hex_nxt[4*d +: 4]),
      .o_seg (w_seg_dec[d])
    );
  end

  // Decoding the next-state registers lands SEG on the same edge as the write
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seg <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        r_seg[d] <= w_blank_nxt[d] ? SEG_BLANK : w_seg_dec[d];
      end
    end
  end

  assign SEG0 = r_seg[0];
  assign SEG1 = r_seg[1];
  assign SEG2 = r_seg[2];
  assign SEG3 = r_seg[3];
  assign SEG4 = r_seg[4];
  assign SEG5 = r_seg[5];

`ifdef IO_KEY_IRQ_EN
  logic                w_wr_mask;
  logic [NUM_KEYS-1:0] r_mask;
  logic                r_irq;

  assign w_wr_mask = bus.io_we && (w_addr == IO_IRQMASK);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_mask) r_mask <= bus.io_wdata[NUM_KEYS-1:0];
      r_irq <= |(r_evt & r_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (bus.io_re) begin
      case (w_addr)
        IO_SW:      w_rdata = {22'b0, r_sw_sync};
        IO_KEYLVL:  w_rdata = {28'b0, r_key_stable};
        IO_KEYEVT:  w_rdata = {28'b0, r_evt};
        IO_LEDREG:  w_rdata = {22'b0, r_led};
        IO_HEX:     w_rdata = {8'b0, r_hex};
        IO_BLANK:   w_rdata = {26'b0, r_blank};
`ifdef IO_KEY_IRQ_EN
        IO_IRQMASK: w_rdata = {28'b0, r_mask};
`else
        IO_IRQMASK: w_rdata = '0;
`endif
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.io_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_port_ctrl
// Brief    : Directed self-checking bench for io_port_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LED;
  logic [6:0] SEG0, SEG1, SEG2, SEG3, SEG4, SEG5;
  logic       irq;

  int checks;
  int failures;

  io_port_ctrl_if bus_if ();

  io_port_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .CNT_W           (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if),
    .KEY   (KEY),
    .SW    (SW),
    .LED   (LED),
    .SEG0  (SEG0),
    .SEG1  (SEG1),
    .SEG2  (SEG2),
    .SEG3  (SEG3),
    .SEG4  (SEG4),
    .SEG5  (SEG5),
    .irq   (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_if.io_addr  = a;
    bus_if.io_wdata = d;
    bus_if.io_we    = 1'b1;
    step(1);
    bus_if.io_we    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus_if.io_addr = a;
    bus_if.io_re   = 1'b1;
    #1;
    check(tag, bus_if.io_rdata, exp);
    bus_if.io_re   = 1'b0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    KEY             = 4'hF;
    SW              = 10'd0;
    bus_if.io_addr  = 8'h00;
    bus_if.io_we    = 1'b0;
    bus_if.io_re    = 1'b0;
    bus_if.io_wdata = 32'h0;
    step(3);
    reset = 1'b0;

    // Reset state
    check("rst_seg", {SEG5, SEG4, SEG3, SEG2, SEG1, SEG0}, {6{7'b1000000}});
    check("rst_led", LED, 32'h0);
    check("rst_irq", irq, 32'h0);
    rd_check("rst_keyevt", 8'h08, 32'h0);
    rd_check("rst_keylvl", 8'h04, 32'h0);

    // Switch synchroniser latency
    SW = 10'd3;
    step(1);
    rd_check("sw_1cyc", 8'h00, 32'h0);
    step(1);
    rd_check("sw_2cyc", 8'h00, 32'h3);
    SW = 10'h3FF;
    step(2);
    rd_check("sw_all", 8'h00, 32'h3FF);
    rd_check("sw_byte_off", 8'h03, 32'h3FF);

    // KEY[1] press: level exactly 18 cycles after the pin change
    KEY = 4'b1101;
    step(17);
    rd_check("key_lvl_17", 8'h04, 32'h0);
    rd_check("key_evt_17", 8'h08, 32'h0);
    step(1);
    rd_check("key_lvl_18", 8'h04, 32'h2);
    rd_check("key_evt_18", 8'h08, 32'h2);
    KEY = 4'hF;
    step(18);
    rd_check("rel_lvl", 8'h04, 32'h0);
    rd_check("rel_evt", 8'h08, 32'h2);
    check("irq_noirq_press", irq, 32'h0);

    // W1C and glitch rejection
    wr(8'h08, 32'h2);
    rd_check("w1c_clear", 8'h08, 32'h0);
    KEY = 4'b1101;
    step(10);
    KEY = 4'hF;
    step(20);
    rd_check("glitch_lvl", 8'h04, 32'h0);
    rd_check("glitch_evt", 8'h08, 32'h0);

    // W1C on the event-set edge: set wins
    KEY = 4'b1101;
    step(17);
    wr(8'h08, 32'h2);
    rd_check("w1c_race_evt", 8'h08, 32'h2);
    rd_check("w1c_race_lvl", 8'h04, 32'h2);
    KEY = 4'hF;
    step(18);
    wr(8'h08, 32'hF);
    rd_check("w1c_all", 8'h08, 32'h0);

    // HEX / BLANK / LED
    wr(8'h10, 32'h0012AB8F);
    check("seg0_F", SEG0, 32'b0001110);
    check("seg5_1", SEG5, 32'b1111001);
    wr(8'h14, 32'h20);
    check("seg1_8", SEG1, 32'b0000000);
    check("seg2_B", SEG2, 32'b0000011);
    check("seg3_A", SEG3, 32'b0001000);
    check("seg4_2", SEG4, 32'b0100100);
    check("seg5_blank", SEG5, 32'b1111111);
    rd_check("hex_rd", 8'h10, 32'h0012AB8F);
    rd_check("blank_rd", 8'h14, 32'h20);

    bus_if.io_addr  = 8'h0C;
    bus_if.io_wdata = 32'hFFFF_F155;
    bus_if.io_we    = 1'b1;
    bus_if.io_re    = 1'b1;
    #1;
    check("led_rd_prewrite", bus_if.io_rdata, 32'h0);
    step(1);
    check("led_rd_postwrite", bus_if.io_rdata, 32'h155);
    bus_if.io_we    = 1'b0;
    bus_if.io_re    = 1'b0;
    #1;
    check("rd_no_re", bus_if.io_rdata, 32'h0);
    check("led_pins", LED, 32'h155);

    wr(8'h1C, 32'hFFFF_FFFF);
    rd_check("unmapped", 8'h1C, 32'h0);

`ifdef IO_KEY_IRQ_EN
    wr(8'h18, 32'h4);
    rd_check("mask_rd", 8'h18, 32'h4);
    KEY = 4'b1101;
    step(20);
    check("irq_masked", irq, 32'h0);
    KEY = 4'b1001;
    step(18);
    rd_check("evt_k2", 8'h08, 32'h6);
    check("irq_latency0", irq, 32'h0);
    step(1);
    check("irq_set", irq, 32'h1);
    wr(8'h08, 32'h4);
    check("irq_clr_edge", irq, 32'h1);
    step(1);
    check("irq_cleared", irq, 32'h0);
`else
    wr(8'h18, 32'hF);
    rd_check("mask_absent", 8'h18, 32'h0);
    KEY = 4'b1001;
    step(20);
    rd_check("evt_k2", 8'h08, 32'h6);
    check("irq_tied", irq, 32'h0);
`endif

    // Reset mid-debounce drops the pending press
    KEY = 4'b1110;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst2_led", LED, 32'h0);
    check("rst2_seg", {SEG5, SEG4, SEG3, SEG2, SEG1, SEG0}, {6{7'b1000000}});
    rd_check("rst2_evt", 8'h08, 32'h0);
    step(17);
    rd_check("rst2_lvl_17", 8'h04, 32'h0);
    step(1);
    rd_check("rst2_lvl_18", 8'h04, 32'h1);
    rd_check("rst2_evt_18", 8'h08, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
